// File: rtl/mem_req_pkg.sv
// Shared types and constants for the EX/MEM request controller.
// The performance-counter constants are only used when MEM_PERF_CNT_EN is defined.
package mem_req_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 3;

  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DUMP   = 2'b01,
    HALTED = 2'b10
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != CNT_MAX)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/mem_pipe_reg.sv
// Generic enable register with asynchronous active-low clear.
// It is used for the EX/MEM and MEM/WB pipeline stages.
module mem_pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_req_ctrl.sv
// Memory request controller: EX/MEM register, request/halt sequencer, MEM/WB register.
// Define MEM_PERF_CNT_EN to add the saturating loadCnt/storeCnt/stallCnt outputs.
module mem_req_ctrl
  import mem_req_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exValid,
  input  logic [DATA_W-1:0] exAddr,
  input  logic [DATA_W-1:0] exWriteData,
  input  logic              exMemRead,
  input  logic              exMemWrite,
  input  logic              exHalt,
  input  logic              exRegWrite,
  input  logic [REG_W-1:0]  exWriteReg,
  input  logic              flush,
  input  logic              memStall,
  input  logic [DATA_W-1:0] memReadData,
  output logic [DATA_W-1:0] addr,
  output logic [DATA_W-1:0] writeData,
  output logic              memRead,
  output logic              memWrite,
  output logic              halt,
  output logic              stallOut,
  output logic              wbValid,
  output logic              wbRegWrite,
  output logic [REG_W-1:0]  wbWriteReg,
  output logic [DATA_W-1:0] wbData,
  output logic              err
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  loadCnt,
  output logic [CNT_W-1:0]  storeCnt,
  output logic [CNT_W-1:0]  stallCnt
`endif
);

  localparam int EXM_W = 2 * DATA_W + REG_W + 5;
  localparam int MWB_W = 1 + REG_W + DATA_W;

  state_t r_state;
  state_t w_next_state;
  logic   r_err;
  logic   w_halt;

  logic [EXM_W-1:0]  w_exm_d;
  logic [EXM_W-1:0]  w_exm_q;
  logic              w_m_valid;
  logic              w_m_halt;
  logic              w_m_reg_write;
  logic              w_m_mem_read;
  logic              w_m_mem_write;
  logic [REG_W-1:0]  w_m_write_reg;
  logic [DATA_W-1:0] w_m_write_data;
  logic [DATA_W-1:0] w_m_addr;

  logic              w_run;
  logic              w_misaligned;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_req_stall;
  logic              w_stall_out;

  logic [MWB_W-1:0]  w_mwb_d;
  logic [MWB_W-1:0]  w_mwb_q;
  logic              w_wb_valid_d;
  logic              w_wb_valid;
  logic              w_wb_reg_write;
  logic [REG_W-1:0]  w_wb_write_reg;
  logic [DATA_W-1:0] w_wb_data;

  // A flushed instruction enters as a bubble; the payload fields are don't-care then.
  assign w_exm_d = {exValid & ~flush, exHalt, exRegWrite, exMemRead, exMemWrite,
                    exWriteReg, exWriteData, exAddr};

  mem_pipe_reg #(.WIDTH(EXM_W)) u_ex_mem (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (~w_stall_out),
    .i_d   (w_exm_d),
    .o_q   (w_exm_q)
  );

  assign {w_m_valid, w_m_halt, w_m_reg_write, w_m_mem_read, w_m_mem_write,
          w_m_write_reg, w_m_write_data, w_m_addr} = w_exm_q;

  assign w_run        = (r_state == RUN);
  assign w_misaligned = w_m_valid & (w_m_mem_read | w_m_mem_write) & w_m_addr[0];
  assign w_mem_read   = w_run & w_m_valid & w_m_mem_read  & ~w_misaligned;
  assign w_mem_write  = w_run & w_m_valid & w_m_mem_write & ~w_misaligned;
  assign w_req_stall  = w_m_valid & (w_mem_read | w_mem_write) & memStall;
  assign w_stall_out  = w_req_stall | ~w_run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_run && (w_next_state == DUMP) && w_misaligned) begin
        r_err <= 1'b1;
      end
    end
  end

  // Inside RUN the only stall source is the memory stage, so w_req_stall stands in for stallOut.
  always_comb begin
    w_next_state = r_state;
    w_halt       = 1'b0;
    case (r_state)
      RUN: begin
        if (w_m_valid && (w_m_halt || w_misaligned) && !w_req_stall) begin
          w_next_state = DUMP;
        end
      end
      DUMP: begin
        w_halt       = 1'b1;
        w_next_state = HALTED;
      end
      HALTED: begin
        w_next_state = HALTED;
      end
      default: begin
        w_next_state = HALTED;
      end
    endcase
  end

  assign w_mwb_d = {w_m_reg_write, w_m_write_reg, w_m_mem_read ? memReadData : w_m_addr};

  mem_pipe_reg #(.WIDTH(MWB_W)) u_mem_wb (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (~w_stall_out),
    .i_d   (w_mwb_d),
    .o_q   (w_mwb_q)
  );

  // The valid bit updates every cycle so a stall drains into a bubble instead of repeating.
  assign w_wb_valid_d = ~w_stall_out & w_m_valid & ~w_misaligned;

  mem_pipe_reg #(.WIDTH(1)) u_wb_valid (
    .clk   (clk),
    .rst_n (rst),
    .i_en  (1'b1),
    .i_d   (w_wb_valid_d),
    .o_q   (w_wb_valid)
  );

  assign {w_wb_reg_write, w_wb_write_reg, w_wb_data} = w_mwb_q;

  assign addr       = w_m_addr;
  assign writeData  = w_m_write_data;
  assign memRead    = w_mem_read;
  assign memWrite   = w_mem_write;
  assign halt       = w_halt;
  assign stallOut   = w_stall_out;
  assign wbValid    = w_wb_valid;
  assign wbRegWrite = w_wb_valid & w_wb_reg_write;
  assign wbWriteReg = w_wb_write_reg;
  assign wbData     = w_wb_data;
  assign err        = r_err;

`ifdef MEM_PERF_CNT_EN
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] r_store_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_load_cnt  <= '0;
      r_store_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_load_cnt  <= sat_inc(r_load_cnt,  w_mem_read  & ~memStall);
      r_store_cnt <= sat_inc(r_store_cnt, w_mem_write & ~memStall);
      r_stall_cnt <= sat_inc(r_stall_cnt, w_stall_out & w_run);
    end
  end

  assign loadCnt  = r_load_cnt;
  assign storeCnt = r_store_cnt;
  assign stallCnt = r_stall_cnt;
`endif

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Sits between the execute stage and the memory stage: EX/MEM pipeline register, memory request sequencer, MEM/WB result register.
- Holds the request (addr, write data, read/write strobes) stable while the memory stage reports stall, and freezes upstream.
- Checks word alignment and sequences halt so the memory dump occurs exactly once, after all older accesses complete.

Parameters:
- DATA_W, 16, data and address width.
- REG_W, 3, destination register index width.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- exValid  in  1  EX holds a valid instruction.
- exAddr  in  DATA_W  effective address / ALU result.
- exWriteData  in  DATA_W  store data.
- exMemRead  in  1  load.
- exMemWrite  in  1  store.
- exHalt  in  1  halt instruction.
- exRegWrite  in  1  writes a register.
- exWriteReg  in  REG_W  destination register.
- flush  in  1  kill the instruction entering from EX this cycle.
- memStall  in  1  stall from memory stage.
- memReadData  in  DATA_W  load data from memory stage.
- addr  out  DATA_W  to memory stage.
- writeData  out  DATA_W  to memory stage.
- memRead  out  1  to memory stage.
- memWrite  out  1  to memory stage.
- halt  out  1  to memory stage (dump strobe).
- stallOut  out  1  freeze EX and earlier stages.
- wbValid  out  1  MEM/WB entry valid.
- wbRegWrite  out  1  gated by wbValid.
- wbWriteReg  out  REG_W  destination.
- wbData  out  DATA_W  load data or address pass-through.
- err  out  1  sticky misalignment error.

Behaviour:
- Reset (rst low, async): all registers 0, FSM RUN; every output 0.
- EX/MEM register (mValid, fields):
  - Loads when ~stallOut.
  - mValid <= exValid & ~flush.
  - memRead/memWrite/addr/writeData are driven from it, with strobes gated by mValid & ~misaligned.
- misaligned = mValid & (mMemRead | mMemWrite) & mAddr[0]. The access is suppressed: no strobe reaches memory.
- stallOut = mValid & (memRead | memWrite) & memStall, or state != RUN.
- MEM/WB register:
  - Loads when ~stallOut.
  - wbValid <= mValid & ~misaligned.
  - wbData <= memReadData if mMemRead, else mAddr.
  - While stalled, holds its value and wbValid drops to 0 after one cycle, so a bubble is inserted.
- Latency: a non-stalled access has data on wbData 1 cycle after the request is presented to memory. Total latency from EX is 2 cycles.
- FSM:
  - RUN: normal operation. If mValid & (mHalt | misaligned) & ~stallOut → DUMP.
  - DUMP: halt=1 for exactly one cycle; strobes 0 → HALTED.
  - HALTED: halt=0, stallOut=1, no further requests; exits only on reset.
- Error handling:
  - err set on entry to DUMP from misaligned.
  - Sticky until reset.
- Simultaneous events:
  - flush with stallOut=1: ignored. EX is frozen, and the flush is reapplied by the hazard unit.
  - flush together with exHalt: the halt is killed.
  - Halt behind a stalled load: the load completes first, then DUMP.
- Reset mid-access drops the request immediately; no partial state survives.

Optional Feature:
- MEM_PERF_CNT_EN.
- Defined: adds outputs loadCnt, storeCnt, stallCnt (16 bits each, saturating at 0xFFFF, reset 0).
  - loadCnt / storeCnt increment per completed memRead / memWrite (strobe & ~memStall).
  - stallCnt increments per cycle with stallOut=1 in RUN.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package mem_req_pkg holds:
  - FSM state encoding (RUN=2'b00, DUMP=2'b01, HALTED=2'b10).
  - DATA_W and REG_W defaults.
  - Counter width and saturation constant.
- One sub-module, mem_pipe_reg: a generic width-parameterised enable register with async active-low reset. It is instantiated for EX/MEM and for MEM/WB.

Test Plan:
- Load, no stall: exAddr=0x0010, exMemRead=1, memReadData=0xBEEF → memRead=1 for one cycle; wbData=0xBEEF and wbValid=1 one cycle later.
- Store with 3-cycle memStall: exAddr=0x0020, data=0x1234 → addr/writeData/memWrite held constant 3 cycles, stallOut=1 for 3 cycles, wbValid=1 once.
- Misaligned load: exAddr=0x0011, memRead → memRead never 1; err=1; halt pulses one cycle; then stallOut stays 1.
- Halt behind stalled load: load stalls 2 cycles, then exHalt → halt=1 exactly once, only after load data is written back.
- flush with exHalt=1 and stallOut=0 → no halt pulse, wbValid=0 next cycle.
- Reset asserted mid-stall → all outputs 0 asynchronously; after release a new load completes normally.
